error_gain_stage: RTL and testbench

//  Front end of the PI integral path. Computes the control error from a reference and feedback

---
 rtl/error_gain_stage_if.sv | 39 +++
 rtl/error_gain_stage.sv | 183 ++++++++++++++++++
 tb/tb_error_gain_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/error_gain_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : error_gain_stage_if
//  Brief    : Sample/result bundle between a control processor and the
//             error gain stage of the PI integral path.
//  Revision : 1.0 - initial release
// ============================================================================
interface error_gain_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16
);

  // Sample side
  logic                   input_valid;
  logic [DATA_WIDTH-1:0]  reference;
  logic [DATA_WIDTH-1:0]  feedback;
  logic [GAIN_WIDTH-1:0]  gain;
  logic                   clear_sat;

  // Result side
  logic [DATA_WIDTH-1:0]  error_out;
  logic [DATA_WIDTH-1:0]  gain_error_out;
  logic                   output_valid;
  logic                   sat_flag;

  // Producer of samples, consumer of results
  modport master (
    output input_valid, reference, feedback, gain, clear_sat,
    input  error_out, gain_error_out, output_valid, sat_flag
  );

  // The gain stage itself
  modport slave (
    input  input_valid, reference, feedback, gain, clear_sat,
    output error_out, gain_error_out, output_valid, sat_flag
  );

endinterface
`default_nettype wire

// File: rtl/error_gain_stage.sv
`default_nettype none
// ============================================================================
//  Module   : error_gain_stage
//  Brief    : Control error (reference - feedback), multiplied by a signed
//             fixed-point integral gain, rounded half toward +inf and
//             saturated. Three-stage pipeline, one sample per clock, with a
//             sticky saturation flag.
//  Revision : 1.0 - initial release
// ============================================================================
module error_gain_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = 12
) (
  input  wire logic         clock,
  input  wire logic         reset,   // asynchronous, active-low
  error_gain_stage_if.slave bus
);

  localparam int c_prod_w = DATA_WIDTH + GAIN_WIDTH;

  // Saturation bounds of the output data range
  localparam logic signed [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Stage 1 : error computation and clamp
  // --------------------------------------------------------------------------
  logic signed [DATA_WIDTH:0]   w_diff;
  logic                         w_ovf1;
  logic signed [DATA_WIDTH-1:0] w_e_clamp;

  logic signed [DATA_WIDTH-1:0] r_e1;
  logic signed [GAIN_WIDTH-1:0] r_g1;
  logic                         r_v1;

  // One extra bit so the difference of two full-range samples never wraps
  assign w_diff = {bus.reference[DATA_WIDTH-1], bus.reference}
                - {bus.feedback[DATA_WIDTH-1],  bus.feedback};

  // Top two bits disagree exactly when the difference leaves the data range
  assign w_ovf1 = w_diff[DATA_WIDTH] ^ w_diff[DATA_WIDTH-1];

  // Clamp the raw difference into the data range
  always_comb begin
    w_e_clamp = w_diff[DATA_WIDTH-1:0];
    if (w_ovf1) begin
      w_e_clamp = w_diff[DATA_WIDTH] ? c_min : c_max;
    end
  end

  // Capture clamped error and its gain; data only loads for valid samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_e1 <= '0;
      r_g1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= bus.input_valid;
      if (bus.input_valid) begin
        r_e1 <= w_e_clamp;
        r_g1 <= bus.gain;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 : full-precision product
  // --------------------------------------------------------------------------
  logic signed [c_prod_w-1:0]   w_e1_ext;
  logic signed [c_prod_w-1:0]   w_g1_ext;
  logic signed [c_prod_w-1:0]   w_prod;

  logic signed [c_prod_w-1:0]   r_p2;
  logic signed [DATA_WIDTH-1:0] r_e2;
  logic                         r_v2;

  // Both operands sign-extended to the product width so the low product
  // bits are exact for signed operands
  assign w_e1_ext = {{GAIN_WIDTH{r_e1[DATA_WIDTH-1]}}, r_e1};
  assign w_g1_ext = {{DATA_WIDTH{r_g1[GAIN_WIDTH-1]}}, r_g1};
  assign w_prod   = w_e1_ext * w_g1_ext;

  // Register product and the matching raw error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p2 <= '0;
      r_e2 <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p2 <= w_prod;
        r_e2 <= r_e1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3 : round, rescale, saturate
  // --------------------------------------------------------------------------
  logic signed [c_prod_w:0]     w_p_ext;
  logic signed [c_prod_w:0]     w_sum;
  logic signed [c_prod_w:0]     w_shift;
  logic [c_prod_w-DATA_WIDTH+1:0] w_hi;
  logic                         w_ovf3;
  logic signed [DATA_WIDTH-1:0] w_r_clamp;

  // Extra headroom bit so adding the rounding term can never wrap
  assign w_p_ext = {r_p2[c_prod_w-1], r_p2};

  // Rounding term only exists when there are fractional bits to drop
  generate
    if (GAIN_FRAC > 0) begin : g_round_on
      localparam logic signed [c_prod_w:0] c_round =
        {{c_prod_w{1'b0}}, 1'b1} << (GAIN_FRAC - 1);
      assign w_sum = w_p_ext + c_round;
    end else begin : g_round_off
      assign w_sum = w_p_ext;
    end
  endgenerate

  // Arithmetic shift: floor of the rounded value, i.e. round half toward +inf
  assign w_shift = w_sum >>> GAIN_FRAC;

  // In range only if all bits from the data sign bit upward agree
  assign w_hi   = w_shift[c_prod_w:DATA_WIDTH-1];
  assign w_ovf3 = !((&w_hi) || !(|w_hi));

  // Clamp the rescaled product into the data range
  always_comb begin
    w_r_clamp = w_shift[DATA_WIDTH-1:0];
    if (w_ovf3) begin
      w_r_clamp = w_shift[c_prod_w] ? c_min : c_max;
    end
  end

  logic [DATA_WIDTH-1:0] r_error_out;
  logic [DATA_WIDTH-1:0] r_gain_error_out;
  logic                  r_output_valid;

  // Output registers load only for valid samples and otherwise hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_error_out      <= '0;
      r_gain_error_out <= '0;
      r_output_valid   <= 1'b0;
    end else begin
      r_output_valid <= r_v2;
      if (r_v2) begin
        r_error_out      <= r_e2;
        r_gain_error_out <= w_r_clamp;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky saturation flag
  // --------------------------------------------------------------------------
  logic w_sat_set;
  logic r_sat_flag;

  // A clamp in either stage of a valid sample sets the flag
  assign w_sat_set = (bus.input_valid & w_ovf1) | (r_v2 & w_ovf3);

  // Set has priority over clear when both happen on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sat_flag <= 1'b0;
    end else if (w_sat_set) begin
      r_sat_flag <= 1'b1;
    end else if (bus.clear_sat) begin
      r_sat_flag <= 1'b0;
    end
  end

  assign bus.error_out      = r_error_out;
  assign bus.gain_error_out = r_gain_error_out;
  assign bus.output_valid   = r_output_valid;
  assign bus.sat_flag       = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_error_gain_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_error_gain_stage
//  Brief    : Self-checking bench for error_gain_stage: a cycle-scheduled
//             arithmetic model compared every cycle, plus literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_error_gain_stage;

  localparam int DW    = 16;
  localparam int GW    = 16;
  localparam int GF    = 12;
  localparam int c_lat = 2;    // edges from capture to output register load
  localparam int c_sz  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  error_gain_stage_if #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) bus ();

  error_gain_stage #(
    .DATA_WIDTH (DW),
    .GAIN_WIDTH (GW),
    .GAIN_FRAC  (GF)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ------------------------------------------------------------------ model
  // Each accepted sample is evaluated arithmetically at capture and its
  // results are scheduled for the edge on which they must appear.
  bit  sch_v  [c_sz];
  int  sch_e  [c_sz];
  int  sch_g  [c_sz];
  bit  sch_s3 [c_sz];
  int  m_cyc = 0;
  bit  m_v   = 0;
  int  m_e   = 0;
  int  m_g   = 0;
  bit  m_sat = 0;

  function automatic longint floordiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clampd(input longint x);
    longint lo, hi;
    lo = -(64'sd1 <<< (DW - 1));
    hi =  (64'sd1 <<< (DW - 1)) - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < c_sz; i++) begin
      sch_v[i]  = 0;
      sch_s3[i] = 0;
    end
    m_v = 0; m_e = 0; m_g = 0; m_sat = 0;
  endtask

  task automatic model_edge();
    int     slot, nslot;
    bit     set;
    longint e_raw, e, p, r_raw, r, half;
    slot  = m_cyc % c_sz;
    nslot = (m_cyc + c_lat) % c_sz;
    set   = 0;
    m_v   = sch_v[slot];
    if (sch_v[slot]) begin
      m_e = sch_e[slot];
      m_g = sch_g[slot];
      set = set | sch_s3[slot];
    end
    sch_v[slot]  = 0;
    sch_s3[slot] = 0;
    if (bus.input_valid) begin
      e_raw = longint'($signed(bus.reference)) - longint'($signed(bus.feedback));
      e     = clampd(e_raw);
      p     = e * longint'($signed(bus.gain));
      half  = (GF > 0) ? (64'sd1 <<< (GF - 1)) : 0;
      r_raw = floordiv(p + half, 64'sd1 <<< GF);
      r     = clampd(r_raw);
      sch_v[nslot]  = 1;
      sch_e[nslot]  = int'(e);
      sch_g[nslot]  = int'(r);
      sch_s3[nslot] = (r != r_raw);
      set = set | (e != e_raw);
    end
    if (set)                m_sat = 1;
    else if (bus.clear_sat) m_sat = 0;
    m_cyc++;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_edge();
    end
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_output_valid", int'(bus.output_valid), int'(m_v));
      check("cyc_sat_flag",     int'(bus.sat_flag),     int'(m_sat));
      check("cyc_error_out",    int'($signed(bus.error_out)),      m_e);
      check("cyc_gain_error",   int'($signed(bus.gain_error_out)), m_g);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int r, input int f, input int g);
    bus.input_valid = 1'b1;
    bus.reference   = DW'(r);
    bus.feedback    = DW'(f);
    bus.gain        = GW'(g);
  endtask

  task automatic idle();
    bus.input_valid = 1'b0;
  endtask

  // Single sample, then wait until its result is visible
  task automatic send(input int r, input int f, input int g);
    drive(r, f, g);
    step();
    idle();
    step();
    step();
  endtask

  task automatic lit(input string name, input int ev, input int gv, input int ov, input int sv);
    check({name, "_err"}, int'($signed(bus.error_out)),      ev);
    check({name, "_gerr"}, int'($signed(bus.gain_error_out)), gv);
    check({name, "_ov"},   int'(bus.output_valid),            ov);
    check({name, "_sat"},  int'(bus.sat_flag),                sv);
  endtask

  initial begin
    bus.input_valid = 1'b0;
    bus.reference   = '0;
    bus.feedback    = '0;
    bus.gain        = '0;
    bus.clear_sat   = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    lit("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // Unity gain
    send(1000, 200, 4096);
    lit("t1", 800, 800, 1, 0);
    step();
    lit("t1_hold", 800, 800, 0, 0);

    // Stage-1 clamp, gain 0.5 rounds up to 16384
    send(32767, -32768, 2048);
    lit("t2", 32767, 16384, 1, 1);
    bus.clear_sat = 1'b1;
    step();
    bus.clear_sat = 1'b0;
    check("t2_clear", int'(bus.sat_flag), 0);

    // -1.5 rounds half up to -1
    send(-3, 0, 2048);
    lit("t3a", -3, -1, 1, 0);
    // Stage-3 clamp
    send(30000, 0, 32767);
    lit("t3b", 30000, 32767, 1, 1);

    // Back-to-back samples
    drive(1, 0, 4096); step();
    drive(2, 0, 4096); step();
    drive(3, 0, 4096); step();
    idle();
    check("t4_ov0", int'(bus.output_valid), 1);
    check("t4_g0",  int'($signed(bus.gain_error_out)), 1);
    step();
    check("t4_ov1", int'(bus.output_valid), 1);
    check("t4_g1",  int'($signed(bus.gain_error_out)), 2);
    step();
    check("t4_ov2", int'(bus.output_valid), 1);
    check("t4_g2",  int'($signed(bus.gain_error_out)), 3);
    step();
    check("t4_ov3", int'(bus.output_valid), 0);

    // Valid, bubble, valid
    drive(5, 0, 4096); step();
    idle();            step();
    drive(7, 0, 4096); step();
    idle();
    check("t4b_ov0", int'(bus.output_valid), 1);
    check("t4b_g0",  int'($signed(bus.gain_error_out)), 5);
    step();
    check("t4b_ov1", int'(bus.output_valid), 0);
    check("t4b_g1",  int'($signed(bus.gain_error_out)), 5);
    step();
    check("t4b_ov2", int'(bus.output_valid), 1);
    check("t4b_g2",  int'($signed(bus.gain_error_out)), 7);
    step();

    // Reset with two samples in flight
    drive(100, 0, 4096); step();
    drive(200, 0, 4096); step();
    idle();
    #1 rst_n = 1'b0;
    #1 lit("t5_rst", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    lit("t5_after", 0, 0, 0, 0);
    send(10, 4, 4096);
    lit("t5_new", 6, 6, 1, 0);

    // Set beats clear on the same edge, clear alone then wins
    drive(32767, -1, 4096);
    bus.clear_sat = 1'b1;
    step();
    idle();
    check("t6_set_wins", int'(bus.sat_flag), 1);
    step();
    bus.clear_sat = 1'b0;
    check("t6_cleared", int'(bus.sat_flag), 0);
    step();
    lit("t6_out", 32767, 32767, 1, 0);

    // Negative stage-1 clamp with unity gain
    send(-32768, 1, 4096);
    lit("t7", -32768, -32768, 1, 1);

    // Negative gain
    send(100, 50, -4096);
    lit("t8", 50, -50, 1, 1);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
